// File: rtl/dual_rail_rx_bridge.sv
// Receiving end of a dual-rail NULL-convention bus: synchronises the rails, classifies
// each wavefront, walks HNULL -> LNULL -> DATA and hands decoded words out on valid/ready.
module dual_rail_rx_bridge #(
    parameter int N_BITS        = 24,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [2*N_BITS-1:0]   i_rail_in,
    output logic [1:0]            o_phase_ack,
    output logic [N_BITS-1:0]     o_data_out,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic [15:0]           o_rx_count,
    output logic                  o_proto_err
);

    typedef enum logic [1:0] {CLS_TRANSIT, CLS_HNULL, CLS_LNULL, CLS_DATA} class_t;
    typedef enum logic [1:0] {ST_WAIT_HNULL, ST_WAIT_LNULL, ST_WAIT_DATA, ST_HOLD} state_t;

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [2*N_BITS-1:0] r_sync [SYNC_STAGES];
    logic [2*N_BITS-1:0] w_synced;
    logic                w_allH, w_allL, w_allD;
    logic [N_BITS-1:0]   w_word;
    class_t              w_class;

    class_t              r_class;
    logic [N_BITS-1:0]   r_word;
    logic [CNT_W-1:0]    r_stableCnt;
    logic                w_stable;

    state_t              r_state, w_nextState;
    logic                r_armed;
    logic [1:0]          r_phaseAck;
    logic [N_BITS-1:0]   r_dataOut;
    logic                r_dataValid;
    logic [15:0]         r_rxCount;
    logic                r_protoErr;

    logic                w_ackLoad;
    logic [1:0]          w_ackVal;
    logic                w_capture;
    logic                w_xfer;
    logic                w_errSet;
    logic                w_arm;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= i_rail_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    // A word is a phase only when every pair agrees; any mix is an in-flight wavefront.
    always_comb begin
        w_allH = 1'b1;
        w_allL = 1'b1;
        w_allD = 1'b1;
        w_word = '0;
        for (int k = 0; k < N_BITS; k++) begin
            w_allH    = w_allH & (w_synced[2*k+1] & w_synced[2*k]);
            w_allL    = w_allL & ~(w_synced[2*k+1] | w_synced[2*k]);
            w_allD    = w_allD & (w_synced[2*k+1] ^ w_synced[2*k]);
            w_word[k] = w_synced[2*k+1];
        end
        if (w_allH)      w_class = CLS_HNULL;
        else if (w_allL) w_class = CLS_LNULL;
        else if (w_allD) w_class = CLS_DATA;
        else             w_class = CLS_TRANSIT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_class     <= CLS_TRANSIT;
            r_word      <= '0;
            r_stableCnt <= '0;
        end else begin
            r_word <= w_word;
            if (w_class != r_class) begin
                r_class     <= w_class;
                r_stableCnt <= CNT_W'(1);
            end else if (r_stableCnt != CNT_W'(STABLE_CYCLES)) begin
                r_stableCnt <= r_stableCnt + 1'b1;
            end
        end
    end

    assign w_stable = (r_stableCnt == CNT_W'(STABLE_CYCLES));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_WAIT_HNULL;
        else          r_state <= w_nextState;
    end

    // The previously accepted phase is ignored; the phase two steps ahead is out of order.
    always_comb begin
        w_nextState = r_state;
        w_ackLoad   = 1'b0;
        w_ackVal    = 2'b00;
        w_capture   = 1'b0;
        w_xfer      = 1'b0;
        w_errSet    = 1'b0;
        w_arm       = 1'b0;
        case (r_state)
            ST_WAIT_HNULL: begin
                if (w_stable && r_class == CLS_HNULL) begin
                    w_nextState = ST_WAIT_LNULL;
                    w_ackLoad   = 1'b1;
                    w_ackVal    = 2'b01;
                    w_arm       = 1'b1;
                end else if (w_stable && r_class == CLS_LNULL && r_armed) begin
                    w_errSet = 1'b1;
                end
            end
            ST_WAIT_LNULL: begin
                if (w_stable && r_class == CLS_LNULL) begin
                    w_nextState = ST_WAIT_DATA;
                    w_ackLoad   = 1'b1;
                    w_ackVal    = 2'b10;
                end else if (w_stable && r_class == CLS_DATA && r_armed) begin
                    w_errSet = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (w_stable && r_class == CLS_DATA) begin
                    w_nextState = ST_HOLD;
                    w_capture   = 1'b1;
                end else if (w_stable && r_class == CLS_HNULL && r_armed) begin
                    w_errSet = 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_dataValid && i_data_ready) begin
                    w_nextState = ST_WAIT_HNULL;
                    w_xfer      = 1'b1;
                    w_ackLoad   = 1'b1;
                    w_ackVal    = 2'b11;
                end
            end
            default: w_nextState = ST_WAIT_HNULL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed     <= 1'b0;
            r_phaseAck  <= 2'b00;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_rxCount   <= '0;
            r_protoErr  <= 1'b0;
        end else begin
            if (w_arm)     r_armed    <= 1'b1;
            if (w_ackLoad) r_phaseAck <= w_ackVal;
            if (w_errSet)  r_protoErr <= 1'b1;
            if (w_capture) begin
                r_dataOut   <= r_word;
                r_dataValid <= 1'b1;
            end else if (w_xfer) begin
                r_dataValid <= 1'b0;
            end
            if (w_xfer) r_rxCount <= r_rxCount + 16'd1;
        end
    end

    assign o_phase_ack  = r_phaseAck;
    assign o_data_out   = r_dataOut;
    assign o_data_valid = r_dataValid;
    assign o_rx_count   = r_rxCount;
    assign o_proto_err  = r_protoErr;

endmodule
